layer_argmax: RTL and testbench
===============================

Name: layer_argmax

Overview:
- Downstream consumer of a fully-connected layer. Captures the layer's flattened signed 16-bit activation vector on the layer's done pulse.
- Scans the vector one element per cycle and reports the index and value of the maximum element.
- Result is held behind a valid/ready handshake for the classifier output or host interface.
- Sits after the final layer of the network.

Parameters:
- M, 4, number of activations in the vector (M >= 1); must match the upstream layer's M.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse, connected to the layer's done; y is sampled on this cycle.
- y  input  M*16  signed Q8.8 activations; element i is y[16*i+15:16*i].
- busy  output  1  high while capturing or scanning (SCAN state).
- valid  output  1  result available.
- ready  input  1  consumer accepts the result when valid&&ready.
- idx  output  IDX_W  index of the maximum; IDX_W = (M>1) ? $clog2(M) : 1.
- max_val  output  16  signed maximum value.
- overrun  output  1  one-cycle pulse when a start is dropped.
- margin  output  16  unsigned (max - second max); present only with LAYER_ARGMAX_MARGIN_EN.

Behaviour:
- Async reset, active low:
  - State goes to IDLE.
  - busy, valid, overrun, idx, max_val, margin all reset to 0.
  - Reset asserted mid-scan aborts the scan; the partial result is discarded.
- States: IDLE, SCAN, HOLD.
- IDLE, start=1:
  - Register y into an internal M*16 buffer.
  - best=y[0], best_idx=0, second=-32768, count=1.
  - Next state is SCAN if M>1, else HOLD.
- SCAN, one element e=buf[count] per cycle:
  - If e > best (signed, strict): second=best, best=e, best_idx=count.
  - Else if e > second: second=e.
  - On the cycle count==M-1 is processed, go to HOLD; otherwise count++.
  - Ties keep the lowest index.
- Latency:
  - start high in cycle t gives valid high from cycle t+M.
  - For M=1, valid is high in cycle t+1.
- HOLD:
  - valid=1; idx, max_val and margin are stable and driven from registers.
  - valid&&ready completes the handshake. Next state is IDLE with valid=0, unless start is also high in the same cycle.
  - start and handshake in the same cycle: capture the new y and go to SCAN (or stay in HOLD with the new result for M=1). This gives back-to-back operation with no bubble.
- Dropped starts:
  - start in SCAN, or in HOLD without ready: ignored, the buffer is untouched, and overrun pulses high the next cycle.
- busy = (state==SCAN).
- idx, max_val and margin update only on entry to HOLD. They keep their last values in IDLE and SCAN.
- No arithmetic overflow: comparisons are 16-bit signed; margin is computed at 17 bits.

Optional Feature:
- LAYER_ARGMAX_MARGIN_EN defined:
  - margin port and second-best tracking are present.
  - margin = best - second as a 17-bit difference, saturated to 16'hFFFF, unsigned.
  - For M=1, margin = 16'hFFFF.
  - Ties give margin 0.
- Not defined: no margin port, no second register, no subtractor. All other behaviour is identical.

Decomposition:
- Shared package nn_pkg:
  - DATA_W=16, FRAC_W=8.
  - typedef signed [DATA_W-1:0] data_t.
  - DATA_MIN = -32768.
  - enum argmax_state_e {IDLE, SCAN, HOLD}.
- One sub-module, argmax_cmp: combinational compare-and-update. It takes (e, best, second, best_idx, count) and produces next best, second and idx, so the tie and ordering rules are unit-testable in isolation.

Test Plan:
- Basic: M=4, y={0x0100,0x0300,0xFF00,0x0200} (elements 0..3), start at t, ready=1 -> valid at t+4, idx=1, max_val=0x0300, margin=0x0100.
- Ties and negatives: M=4, y={0xFF80,0xFF80,0x8000,0x8000} -> idx=0, max_val=0xFF80, margin=0. All 0x8000 -> idx=0, margin=0.
- Backpressure and overrun:
  - ready=0 for 10 cycles after valid: outputs stable, valid held.
  - A second start during HOLD gives an overrun pulse next cycle and the result is unchanged.
  - A start during SCAN also gives an overrun pulse.
- Back-to-back: start held for the same cycle as valid&&ready with new y={0,0,0,0x0500} -> the next valid reports idx=3, max_val=0x0500 with no IDLE cycle.
- Reset mid-scan: rst_n low at t+2 -> all outputs 0 immediately. A fresh start after release gives a correct result.
- Edge and wide cases:
  - M=1, y=0x8000 -> valid at t+1, idx=0, margin=0xFFFF.
  - M=8, y={0x7FFF,0x8000,...} -> margin saturates to 0xFFFF.

Source files
------------

// File: rtl/layer_argmax_pkg.sv
// nn_pkg: shared types and constants for the network's output stages.
//   DATA_W/FRAC_W   : Q8.8 activation format
//   data_t          : signed activation word
//   DATA_MIN        : most negative activation, used to seed second-best
//   argmax_state_e  : layer_argmax controller states
//   sat_margin()    : best - second at 17 bits, clamped to 16-bit unsigned
//                     (only with LAYER_ARGMAX_MARGIN_EN)
package nn_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    typedef logic signed [DATA_W-1:0] data_t;

    localparam data_t DATA_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } argmax_state_e;

`ifdef LAYER_ARGMAX_MARGIN_EN
    // The difference is formed one bit wider so +32767 - (-32768) cannot wrap.
    function automatic logic [DATA_W-1:0] sat_margin(input data_t hi, input data_t lo);
        logic signed [DATA_W:0] d;
        d = {hi[DATA_W-1], hi} - {lo[DATA_W-1], lo};
        if (d < 0)
            return '0;
        else if (d > 17'sh0FFFF)
            return '1;
        else
            return d[DATA_W-1:0];
    endfunction
`endif

endpackage

// File: rtl/layer_argmax_cmp.sv
// argmax_cmp: combinational compare-and-update step of the argmax scan.
//   e            : element under test
//   best/best_idx: running maximum and its index
//   count        : index of e
//   second       : running second maximum (LAYER_ARGMAX_MARGIN_EN only)
//   next_*       : updated running values
// A strict greater-than keeps the lowest index on ties.
module argmax_cmp
    import nn_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  data_t              e,
    input  data_t              best,
    input  logic [IDX_W-1:0]   best_idx,
    input  logic [IDX_W-1:0]   count,
`ifdef LAYER_ARGMAX_MARGIN_EN
    input  data_t              second,
    output data_t              next_second,
`endif
    output data_t              next_best,
    output logic [IDX_W-1:0]   next_idx
);

    always_comb begin
        next_best = best;
        next_idx  = best_idx;
`ifdef LAYER_ARGMAX_MARGIN_EN
        next_second = second;
`endif
        if (e > best) begin
            next_best = e;
            next_idx  = count;
`ifdef LAYER_ARGMAX_MARGIN_EN
            next_second = best;
`endif
        end
`ifdef LAYER_ARGMAX_MARGIN_EN
        else if (e > second) begin
            next_second = e;
        end
`endif
    end

endmodule

// File: rtl/layer_argmax.sv
// layer_argmax: captures a fully-connected layer's activation vector on its
// done pulse, scans it one element per cycle and holds the index and value of
// the maximum behind a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start, y   : capture strobe and M x Q8.8 activations (element i = y[16i+15:16i])
//   busy       : scan in progress
//   valid/ready: result handshake; idx/max_val held while valid
//   overrun    : one-cycle pulse after a start that could not be accepted
//   margin     : best - second best, saturated unsigned
//                (present only when LAYER_ARGMAX_MARGIN_EN is defined)
module layer_argmax
    import nn_pkg::*;
#(
    parameter int M = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [M*DATA_W-1:0]               y,
    output logic                              busy,
    output logic                              valid,
    input  logic                              ready,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] idx,
    output logic [DATA_W-1:0]                 max_val,
    output logic                              overrun
`ifdef LAYER_ARGMAX_MARGIN_EN
    ,
    output logic [DATA_W-1:0]                 margin
`endif
);

    localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

    argmax_state_e     state;
    data_t             vbuf [M];
    data_t             best;
    logic [IDX_W-1:0]  best_idx;
    logic [IDX_W-1:0]  count;
    data_t             e;
    data_t             nbest;
    logic [IDX_W-1:0]  nidx;
    data_t             y0;
    logic              hs;
    logic              take;
`ifdef LAYER_ARGMAX_MARGIN_EN
    data_t             second;
    data_t             nsecond;
`endif

    assign y0 = data_t'(y[DATA_W-1:0]);
    assign e  = vbuf[count];

    // A start is accepted from IDLE, or in HOLD when the result is consumed
    // in the same cycle (back-to-back operation).
    assign hs   = (state == HOLD) && ready;
    assign take = start && ((state == IDLE) || hs);

    argmax_cmp #(
        .IDX_W (IDX_W)
    ) u_cmp (
        .e           (e),
        .best        (best),
        .best_idx    (best_idx),
        .count       (count),
`ifdef LAYER_ARGMAX_MARGIN_EN
        .second      (second),
        .next_second (nsecond),
`endif
        .next_best   (nbest),
        .next_idx    (nidx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            idx      <= '0;
            max_val  <= '0;
            best     <= '0;
            best_idx <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < M; i++)
                vbuf[i] <= '0;
`ifdef LAYER_ARGMAX_MARGIN_EN
            second   <= '0;
            margin   <= '0;
`endif
        end else begin
            overrun <= start && !take;
            if (take) begin
                for (int unsigned i = 0; i < M; i++)
                    vbuf[i] <= data_t'(y[DATA_W*i +: DATA_W]);
                best     <= y0;
                best_idx <= '0;
                count    <= IDX_W'(1);
`ifdef LAYER_ARGMAX_MARGIN_EN
                second   <= DATA_MIN;
`endif
                if (M > 1) begin
                    state <= SCAN;
                    busy  <= 1'b1;
                    valid <= 1'b0;
                end else begin
                    // Single element: the result is known at capture.
                    state   <= HOLD;
                    busy    <= 1'b0;
                    valid   <= 1'b1;
                    idx     <= '0;
                    max_val <= y0;
`ifdef LAYER_ARGMAX_MARGIN_EN
                    margin  <= '1;
`endif
                end
            end else begin
                case (state)
                    SCAN: begin
                        best     <= nbest;
                        best_idx <= nidx;
`ifdef LAYER_ARGMAX_MARGIN_EN
                        second   <= nsecond;
`endif
                        if (count == IDX_W'(M - 1)) begin
                            state   <= HOLD;
                            busy    <= 1'b0;
                            valid   <= 1'b1;
                            idx     <= nidx;
                            max_val <= nbest;
`ifdef LAYER_ARGMAX_MARGIN_EN
                            margin  <= sat_margin(nbest, nsecond);
`endif
                        end else begin
                            count <= count + IDX_W'(1);
                        end
                    end
                    HOLD: begin
                        if (ready) begin
                            state <= IDLE;
                            valid <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_argmax.sv
`timescale 1ns/1ps
module tb_layer_argmax;
    import nn_pkg::*;

    localparam int NI = 3;

    typedef struct {
        int          vcyc;
        int          idx;
        logic [15:0] mx;
        logic [15:0] mg;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [NI-1:0]        start_v;
    logic [NI-1:0]        ready_v;
    logic [NI-1:0][127:0] y_v;
    wire  [NI-1:0]        busy_v;
    wire  [NI-1:0]        valid_v;
    wire  [NI-1:0]        ov_v;
    wire  [NI-1:0][15:0]  mx_v;
    wire  [1:0]           idx_m4;
    wire                  idx_m1;
    wire  [2:0]           idx_m8;
`ifdef LAYER_ARGMAX_MARGIN_EN
    wire  [NI-1:0][15:0]  mg_v;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    layer_argmax #(.M(4)) u_m4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .y(y_v[0][63:0]),
        .busy(busy_v[0]), .valid(valid_v[0]), .ready(ready_v[0]),
        .idx(idx_m4), .max_val(mx_v[0]), .overrun(ov_v[0])
`ifdef LAYER_ARGMAX_MARGIN_EN
        , .margin(mg_v[0])
`endif
    );

    layer_argmax #(.M(1)) u_m1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .y(y_v[1][15:0]),
        .busy(busy_v[1]), .valid(valid_v[1]), .ready(ready_v[1]),
        .idx(idx_m1), .max_val(mx_v[1]), .overrun(ov_v[1])
`ifdef LAYER_ARGMAX_MARGIN_EN
        , .margin(mg_v[1])
`endif
    );

    layer_argmax #(.M(8)) u_m8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .y(y_v[2]),
        .busy(busy_v[2]), .valid(valid_v[2]), .ready(ready_v[2]),
        .idx(idx_m8), .max_val(mx_v[2]), .overrun(ov_v[2])
`ifdef LAYER_ARGMAX_MARGIN_EN
        , .margin(mg_v[2])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int m_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic int get_idx(input int k);
        case (k)
            0:       return int'(idx_m4);
            1:       return int'(idx_m1);
            default: return int'(idx_m8);
        endcase
    endfunction

    function automatic logic [15:0] get_mg(input int k);
`ifdef LAYER_ARGMAX_MARGIN_EN
        return mg_v[k];
`else
        return (k < 0) ? 16'h0001 : 16'h0000;
`endif
    endfunction

    // Reference: first index of the maximum; margin from the two largest
    // entries of the sorted vector.
    function automatic exp_t ref_model(input logic [127:0] v, input int n, input int vc);
        exp_t r;
        int   vals[$];
        int   bi;
        int   d;
        for (int i = 0; i < n; i++) begin
            logic signed [15:0] el;
            el = v[16*i +: 16];
            vals.push_back(int'(el));
        end
        bi = 0;
        for (int i = 1; i < n; i++)
            if (vals[i] > vals[bi]) bi = i;
        r.vcyc = vc;
        r.idx  = bi;
        r.mx   = 16'(vals[bi]);
        vals.rsort();
        if (n == 1) begin
            r.mg = 16'hFFFF;
        end else begin
            d = vals[0] - vals[1];
            r.mg = (d > 65535) ? 16'hFFFF : 16'(d);
        end
        return r;
    endfunction

    // Scoreboard queues, one per instance.
    exp_t q0[$], q1[$], q2[$];

    function automatic void qpush(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic chk(input string nm, input int k, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", nm, k, cyc, act, expv);
        end
    endtask

    function automatic logic [15:0] relem();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFF80;
            3:       return 16'h0000;
            4:       return 16'h0100;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [127:0] rvec();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = relem();
        return v;
    endfunction

    function automatic logic [127:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] c, input logic [15:0] d);
        logic [127:0] v;
        v = rvec();
        v[63:0] = {d, c, b, a};
        return v;
    endfunction

    // Transaction-level timing model: a result accepted in cycle t is presented
    // from t+M until the first cycle with ready; a new start is accepted when
    // nothing is outstanding or the result is consumed in that cycle.
    int outst  [NI];
    int acc    [NI];
    int res    [NI];
    bit ov_pend[NI];
    bit e_busy [NI];
    bit e_valid[NI];
    bit e_ov   [NI];

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            outst[k] = 0; ov_pend[k] = 1'b0;
            e_busy[k] = 1'b0; e_valid[k] = 1'b0; e_ov[k] = 1'b0;
        end
        q0.delete(); q1.delete(); q2.delete();
    endtask

    task automatic step();
        for (int k = 0; k < NI; k++) begin
            bit hold, hsk, tk;
            hold = (outst[k] != 0) && (cyc >= res[k]);
            hsk  = hold && ready_v[k];
            tk   = start_v[k] && ((outst[k] == 0) || hsk);
            e_valid[k] = hold;
            e_busy[k]  = (outst[k] != 0) && (cyc > acc[k]) && (cyc < res[k]);
            e_ov[k]    = ov_pend[k];
            ov_pend[k] = start_v[k] && !tk;
            if (hsk) outst[k] = 0;
            if (tk) begin
                outst[k] = 1;
                acc[k]   = cyc;
                res[k]   = cyc + m_of(k);
                qpush(k, ref_model(y_v[k], m_of(k), cyc + m_of(k)));
            end
        end
        @(posedge clk);
        #1;
        start_v = '0;
        for (int k = 0; k < NI; k++) y_v[k] = rvec();
    endtask

    task automatic check_zero(input string nm);
        for (int k = 0; k < NI; k++) begin
            chk({nm, "_busy"},    k, busy_v[k],  0);
            chk({nm, "_valid"},   k, valid_v[k], 0);
            chk({nm, "_overrun"}, k, ov_v[k],    0);
            chk({nm, "_idx"},     k, get_idx(k), 0);
            chk({nm, "_max"},     k, mx_v[k],    0);
`ifdef LAYER_ARGMAX_MARGIN_EN
            chk({nm, "_margin"},  k, get_mg(k),  0);
`endif
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_v = '0;
        #1;
        check_zero("rst_mid");
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever a fresh result is presented and
    // checks held results against it on every following cycle.
    exp_t cur[NI];
    bit   pv [NI];
    bit   phs[NI];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                pv[k] = 1'b0;
                phs[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                chk("valid",   k, valid_v[k], e_valid[k]);
                chk("busy",    k, busy_v[k],  e_busy[k]);
                chk("overrun", k, ov_v[k],    e_ov[k]);
                if (valid_v[k]) begin
                    if (!pv[k] || phs[k]) begin
                        if (qsize(k) == 0) begin
                            chk("unexpected_result", k, 1, 0);
                        end else begin
                            cur[k] = qpop(k);
                            chk("latency", k, cyc, cur[k].vcyc);
                        end
                    end
                    chk("idx", k, get_idx(k), cur[k].idx);
                    chk("max_val", k, mx_v[k], cur[k].mx);
`ifdef LAYER_ARGMAX_MARGIN_EN
                    chk("margin", k, get_mg(k), cur[k].mg);
`endif
                end
                pv[k]  = valid_v[k];
                phs[k] = valid_v[k] && ready_v[k];
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        ready_v = '0;
        for (int k = 0; k < NI; k++) y_v[k] = rvec();
        model_clear();
        #3;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic vector; single element 0x8000; saturating wide vector.
        ready_v = '1;
        y_v[0] = pack4(16'h0100, 16'h0300, 16'hFF00, 16'h0200);
        y_v[1][15:0] = 16'h8000;
        y_v[2] = {{7{16'h8000}}, 16'h7FFF};
        start_v = '1;
        step();
        repeat (10) step();

        // Ties and negatives.
        y_v[0] = pack4(16'hFF80, 16'hFF80, 16'h8000, 16'h8000);
        start_v = '1;
        step();
        repeat (10) step();
        for (int k = 0; k < NI; k++) y_v[k] = {8{16'h8000}};
        start_v = '1;
        step();
        repeat (10) step();

        // Backpressure with starts dropped in SCAN and in HOLD.
        ready_v = '0;
        start_v = '1;
        step();
        step();
        start_v = '1;
        step();
        repeat (3) step();
        start_v = '1;
        step();
        repeat (6) step();
        ready_v = '1;
        repeat (10) step();

        // Back-to-back: new start in the handshake cycle of the M=4 instance.
        ready_v = '0;
        start_v = '1;
        step();
        repeat (3) step();
        ready_v = '1;
        y_v[0] = pack4(16'h0000, 16'h0000, 16'h0000, 16'h0500);
        start_v = '1;
        step();
        repeat (12) step();

        // Reset in the middle of a scan, then a fresh run.
        start_v = '1;
        step();
        step();
        do_reset();
        start_v = '1;
        step();
        repeat (12) step();

        // Randomised traffic.
        repeat (1500) begin
            for (int k = 0; k < NI; k++) begin
                ready_v[k] = ($urandom_range(0, 9) < 7);
                start_v[k] = ($urandom_range(0, 9) < 3);
            end
            step();
        end

        // Drain.
        start_v = '0;
        ready_v = '1;
        repeat (20) step();
        for (int k = 0; k < NI; k++) chk("drain", k, qsize(k), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
